// File: rtl/alarm_snooze.sv
// Alarm ringing controller: turns the comparator match into a buzzer drive with snooze, stop and auto-timeout.
// Latency: one cycle; buzz rises on the edge after the first match cycle, and every output is registered.
// No backpressure: button and match levels are sampled every cycle and nothing upstream is ever stalled.
module alarm_snooze #(
  parameter int unsigned SNOOZE_SEC = 540,
  parameter int unsigned RING_SEC   = 120,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alarm_on,
  input  logic       match,
  input  logic       snooze_btn,
  input  logic       stop_btn,
  output logic       buzz,
  output logic [1:0] state,
  output logic [9:0] snooze_left,
  output logic [2:0] snooze_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [9:0] SNOOZE_LOAD = 10'(SNOOZE_SEC);
  localparam logic [9:0] RING_LAST   = 10'(RING_SEC - 1);
  localparam logic [2:0] SNOOZE_MAX  = 3'(MAX_SNOOZE);

  state_t     state_q, state_d;
  logic       buzz_q, buzz_d;
  logic [9:0] ring_cnt_q, ring_cnt_d;
  logic [9:0] snooze_left_q, snooze_left_d;
  logic [2:0] snooze_cnt_q, snooze_cnt_d;
  logic       match_q;
  logic       snz_q;

  logic       match_rise;
  logic       snz_rise;

  // Rising edges come from the copies of last cycle's levels. After reset
  // the copies are 0, so a match still high at release counts as a new rise.
  assign match_rise = match & ~match_q;
  assign snz_rise   = snooze_btn & ~snz_q;

  // Edge-detect history, updated every cycle regardless of state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_q <= 1'b0;
      snz_q   <= 1'b0;
    end else begin
      match_q <= match;
      snz_q   <= snooze_btn;
    end
  end

  // Next-state logic; in active states the order is alarm_on, stop, snooze, timeout/expiry.
  always_comb begin
    state_d       = state_q;
    ring_cnt_d    = ring_cnt_q;
    snooze_left_d = snooze_left_q;
    snooze_cnt_d  = snooze_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (alarm_on && match_rise) begin
          state_d      = RING;
          ring_cnt_d   = '0;
          snooze_cnt_d = '0;
        end
      end

      RING: begin
        if (!alarm_on) begin
          state_d       = IDLE;
          snooze_left_d = '0;
        end else if (stop_btn) begin
          state_d       = DONE;
          snooze_left_d = '0;
        end else if (snz_rise && (snooze_cnt_q < SNOOZE_MAX)) begin
          state_d       = SNOOZE;
          snooze_left_d = SNOOZE_LOAD;
          snooze_cnt_d  = snooze_cnt_q + 3'd1;
        end else if (ring_cnt_q == RING_LAST) begin
          // A snooze press beyond the allowance falls through to here, so
          // the ring keeps counting towards its timeout.
          state_d = DONE;
        end else begin
          ring_cnt_d = ring_cnt_q + 10'd1;
        end
      end

      SNOOZE: begin
        if (!alarm_on) begin
          state_d       = IDLE;
          snooze_left_d = '0;
        end else if (stop_btn) begin
          state_d       = DONE;
          snooze_left_d = '0;
        end else if (snooze_left_q == 10'd1) begin
          state_d       = RING;
          ring_cnt_d    = '0;
          snooze_left_d = '0;
        end else begin
          // A fresh snooze press here is deliberately ignored.
          snooze_left_d = snooze_left_q - 10'd1;
        end
      end

      DONE: begin
        // Hold while the minute still matches so the same alarm never re-rings.
        if (!alarm_on || !match) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    buzz_d = (state_d == RING);
  end

  // State and output registers; reset drops the buzzer immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      buzz_q        <= 1'b0;
      ring_cnt_q    <= '0;
      snooze_left_q <= '0;
      snooze_cnt_q  <= '0;
    end else begin
      state_q       <= state_d;
      buzz_q        <= buzz_d;
      ring_cnt_q    <= ring_cnt_d;
      snooze_left_q <= snooze_left_d;
      snooze_cnt_q  <= snooze_cnt_d;
    end
  end

  assign buzz        = buzz_q;
  assign state       = state_q;
  assign snooze_left = snooze_left_q;
  assign snooze_cnt  = snooze_cnt_q;

endmodule

// File: doc/alarm_snooze.md
# alarm_snooze

Alarm ringing controller that sits directly downstream of the alarm comparator in the digital-clock top level. It consumes the comparator's "time equals alarm" match and the Alarmon switch, and produces the buzzer drive with snooze, stop and auto-timeout behaviour. It replaces the plain `buzz && Alarmon` gating. It runs on the 1 Hz Pulse clock, so one cycle equals one second.

## Interface
Parameters:
- SNOOZE_SEC, default 540: buzzer-off interval per snooze, in cycles. Legal range is 1..1023.
- RING_SEC, default 120: maximum continuous ring before auto-stop, in cycles. Legal range is 1..1023.
- MAX_SNOOZE, default 3: snoozes allowed per alarm event. Legal range is 0..7.

Ports:
- clk  in  1  Pulse clock, 1 cycle/sec; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- alarm_on  in  1  Alarmon switch; synchronous to clk.
- match  in  1  alarm comparator output; high for every cycle the time matches the alarm setting.
- snooze_btn  in  1  snooze button, level; acted on at its rising edge.
- stop_btn  in  1  stop button, level; acted on whenever high.
- buzz  out  1  buzzer drive, registered.
- state  out  2  IDLE=0, RING=1, SNOOZE=2, DONE=3.
- snooze_left  out  10  seconds remaining in SNOOZE; 0 in all other states.
- snooze_cnt  out  3  snoozes used in the current alarm event.

## Operation
- Reset (rst=0, asynchronous):
  - state=IDLE, buzz=0, snooze_left=0, snooze_cnt=0.
  - Internal ring counter=0.
  - match_d=0, snz_d=0.
- Edge detects use registered copies: match_rise = match & ~match_d; snz_rise = snooze_btn & ~snz_d. Both registers update every cycle.
- Priority within any active state (RING, SNOOZE): alarm_on=0 > stop_btn > snz_rise > timeout/expiry.
- IDLE (buzz=0):
  - alarm_on & match_rise -> RING, with ring counter=0 and snooze_cnt=0.
  - Turning alarm_on high while match is already high produces no rise, so the alarm does not ring.
- RING (buzz=1):
  - alarm_on=0 -> IDLE.
  - stop_btn=1 -> DONE.
  - snz_rise with snooze_cnt<MAX_SNOOZE -> SNOOZE, with snooze_left=SNOOZE_SEC and snooze_cnt+1.
  - snz_rise with snooze_cnt=MAX_SNOOZE is ignored; the block keeps ringing.
  - Ring counter = RING_SEC-1 -> DONE (timeout). Otherwise ring counter+1.
- SNOOZE (buzz=0):
  - alarm_on=0 -> IDLE.
  - stop_btn=1 -> DONE.
  - Otherwise snooze_left decrements. When snooze_left=1 -> RING, with ring counter=0 and snooze_left=0.
  - snz_rise in SNOOZE is ignored; it does not restart the interval.
- DONE (buzz=0):
  - Stays in DONE while match=1, so the block never re-rings within the same matching minute.
  - match=0 -> IDLE.
  - alarm_on=0 -> IDLE immediately.
- Leaving RING/SNOOZE to IDLE or DONE clears snooze_left to 0. snooze_cnt holds until the next IDLE->RING transition.
- Width rules:
  - Ring counter and snooze_left are 10-bit unsigned and never wrap.
  - The parameter limits above guarantee a counter stays at or below its load value.

## Timing
- All outputs are registered and change only on a clk rising edge or on asynchronous reset assertion.
- Ring start: if match first goes high in cycle n, buzz=1 from cycle n+1.
- Ring length: buzz stays high for exactly RING_SEC cycles when no button is pressed.
- Snooze: with snz_rise sampled at edge k, buzz=0 from k+1 for exactly SNOOZE_SEC cycles, then buzz=1 again.
- Stop: stop_btn sampled high at edge k -> buzz=0 from k+1.
- Simultaneous stop_btn and snz_rise -> stop wins, state goes to DONE.
- Simultaneous alarm_on=0 with anything else -> IDLE.
- Reset mid-ring or mid-snooze: buzz drops immediately. After release, a match still high counts as a rise (match_d=0), so the alarm rings again one cycle later.

## Test plan
Bench parameters: SNOOZE_SEC=5, RING_SEC=4, MAX_SNOOZE=2.

- Timeout: alarm_on=1, match rises at cycle 10 and holds 60 cycles -> buzz high cycles 11-14, state=DONE from cycle 15 until match falls, then IDLE; no second ring.
- Snooze: ring starts at cycle 11; snooze_btn pulse at cycle 12 -> buzz=0 cycles 13-17; snooze_left reads 5,4,3,2,1; buzz=1 from cycle 18; snooze_cnt=1.
- Snooze limit: three snooze presses across successive rings -> the first two snooze; the third is ignored with buzz held high; snooze_cnt=2; timeout then sends state to DONE.
- Priority: stop_btn and a snooze_btn rising edge in the same RING cycle -> state=DONE, snooze_cnt unchanged. alarm_on dropped during SNOOZE -> IDLE, snooze_left=0.
- No-edge arming: match already high when alarm_on goes 0->1 -> buzz stays 0 for the whole matching window.
- Async reset: rst pulled low mid-SNOOZE between clock edges -> buzz=0, state=IDLE, snooze_left=0, snooze_cnt=0 immediately. With match high at release -> buzz=1 one cycle after the first edge.
